// File: rtl/fence_point_loader.sv
//------------------------------------------------------------------------------
// fence_point_loader
//------------------------------------------------------------------------------
// Input stage of the geofence datapath. Captures one object point followed by
// six fence-vertex points from the shared X/Y bus, one point per rising edge.
// Each point is packed as {X,Y}. All seven points are held stable for the
// downstream vertex sorter. The loader then waits for the final-stage valid
// strobe before it accepts the next frame.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   X, Y         coordinates of the current point (CW bits each)
//   valid        end-of-frame strobe from the inside-test stage
//   obj          object point {X,Y}, with X in the upper CW bits
//   g1..g6       fence vertices in arrival order, packed like obj
//   finish_load  one-cycle pulse after the seventh point is captured
//   load_busy    high while the loader is capturing points
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fence_point_loader #(
    parameter int CW    = 10,
    parameter int NVERT = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   X,
    input  logic [CW-1:0]   Y,
    input  logic            valid,
    output logic [2*CW-1:0] obj,
    output logic [2*CW-1:0] g1,
    output logic [2*CW-1:0] g2,
    output logic [2*CW-1:0] g3,
    output logic [2*CW-1:0] g4,
    output logic [2*CW-1:0] g5,
    output logic [2*CW-1:0] g6,
    output logic            finish_load,
    output logic            load_busy
);

    // Slot 0 holds the object point. Slots 1..NVERT hold the vertices.
    localparam int          c_NPTS = NVERT + 1;
    localparam logic [2:0]  c_LAST = 3'(NVERT);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              r_finish;
    logic              w_finish_nxt;
    logic [2*CW-1:0]   r_pts [c_NPTS];
    logic [2*CW-1:0]   w_pt;

    assign w_pt = {X, Y};

    //--------------------------------------------------------------------------
    // State, counter and completion-pulse registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_LOAD;
            r_cnt    <= 3'd0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_LOAD: begin
                // Every LOAD edge is a capture. The last slot closes the frame.
                // valid is ignored here, so a long valid strobe cannot restart
                // a frame that has already begun.
                if (r_cnt == c_LAST) begin
                    w_state_nxt  = S_WAIT;
                    w_cnt_nxt    = 3'd0;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_WAIT: begin
                if (valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Point registers. The slot selected by the counter is written. Slots that
    // have not been rewritten yet keep the previous frame until overwritten.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NPTS; i++) begin
                r_pts[i] <= '0;
            end
        end else if (r_state == S_LOAD) begin
            for (int i = 0; i < c_NPTS; i++) begin
                if (r_cnt == 3'(i)) begin
                    r_pts[i] <= w_pt;
                end
            end
        end
    end

    assign obj         = r_pts[0];
    assign g1          = r_pts[1];
    assign g2          = r_pts[2];
    assign g3          = r_pts[3];
    assign g4          = r_pts[4];
    assign g5          = r_pts[5];
    assign g6          = r_pts[6];
    assign finish_load = r_finish;
    assign load_busy   = (r_state == S_LOAD);

endmodule

`default_nettype wire
